// File: rtl/alu_result_buffer_if.sv
// ---------------------------------------------------------------------------
// alu_result_buffer_if
// Handshake and data bundle between the ALU result producer, the result
// buffer and the writeback/bus consumer.
//   in_valid/in_ready            : producer -> buffer handshake
//   in_zlow/in_zhigh/in_wide     : ALU result words and double-width flag
//   out_valid/out_ready          : buffer -> consumer handshake
//   out_zlow/out_zhigh/out_wide  : head entry data
//   out_zero/out_neg             : head entry flags captured at push time
//   count                        : number of occupied entries
// modport master : the producer/consumer side (drives in_* and out_ready)
// modport slave  : the buffer itself
// ---------------------------------------------------------------------------
interface alu_result_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_zlow;
    logic [DATA_WIDTH-1:0] in_zhigh;
    logic                  in_wide;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_zlow;
    logic [DATA_WIDTH-1:0] out_zhigh;
    logic                  out_wide;
    logic                  out_zero;
    logic                  out_neg;
    logic [CNT_W-1:0]      count;

    modport master (
        output in_valid, in_zlow, in_zhigh, in_wide, out_ready,
        input  in_ready, out_valid, out_zlow, out_zhigh, out_wide,
               out_zero, out_neg, count
    );

    modport slave (
        input  in_valid, in_zlow, in_zhigh, in_wide, out_ready,
        output in_ready, out_valid, out_zlow, out_zhigh, out_wide,
               out_zero, out_neg, count
    );
endinterface

// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
// Registered FIFO stage behind the combinational ALU units. Each accepted
// result is stored with its zero/negative flags, and the oldest entry is
// presented to the writeback side. Breaks the timing path at the ALU output.
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-high reset (empties the buffer)
//   flush : synchronous discard of all entries, overrides push/pop
//   bus   : alu_result_buffer_if.slave (handshakes, data, flags, count)
// ---------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  flush,
    alu_result_buffer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      cnt;

    // Storage is not reset: only the control state decides what is visible.
    logic [DATA_WIDTH-1:0] zlow_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] zhigh_mem [DEPTH];
    logic                  wide_mem  [DEPTH];
    logic                  zero_mem  [DEPTH];
    logic                  neg_mem   [DEPTH];

    logic                  push;
    logic                  pop;

    // Zero over the full result: the high word only counts for wide results.
    function automatic logic flag_zero(input logic [DATA_WIDTH-1:0] zl,
                                       input logic [DATA_WIDTH-1:0] zh,
                                       input logic                  wide);
        return (zl == '0) && (!wide || (zh == '0));
    endfunction

    // Sign bit of the most significant word actually produced.
    function automatic logic flag_neg(input logic [DATA_WIDTH-1:0] zl,
                                      input logic [DATA_WIDTH-1:0] zh,
                                      input logic                  wide);
        return wide ? zh[DATA_WIDTH-1] : zl[DATA_WIDTH-1];
    endfunction

    // in_ready depends only on registered occupancy, never on out_ready.
    assign bus.in_ready  = (cnt != CNT_W'(DEPTH));
    assign bus.out_valid = (cnt != '0);
    assign bus.count     = cnt;

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Head entry is gated to zero when empty so outputs read as reset values
    // straight after clear, independent of the uninitialised storage.
    assign bus.out_zlow  = bus.out_valid ? zlow_mem[rd_ptr]  : '0;
    assign bus.out_zhigh = bus.out_valid ? zhigh_mem[rd_ptr] : '0;
    assign bus.out_wide  = bus.out_valid & wide_mem[rd_ptr];
    assign bus.out_zero  = bus.out_valid & zero_mem[rd_ptr];
    assign bus.out_neg   = bus.out_valid & neg_mem[rd_ptr];

    // ---- capture stage: result and flags written into the tail slot ----
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            zlow_mem[wr_ptr]  <= bus.in_zlow;
            zhigh_mem[wr_ptr] <= bus.in_wide ? bus.in_zhigh : '0;
            wide_mem[wr_ptr]  <= bus.in_wide;
            zero_mem[wr_ptr]  <= flag_zero(bus.in_zlow, bus.in_zhigh, bus.in_wide);
            neg_mem[wr_ptr]   <= flag_neg(bus.in_zlow, bus.in_zhigh, bus.in_wide);
        end
    end

    // ---- control stage: pointers wrap naturally (DEPTH is a power of two);
    //      full/empty come from cnt, not pointer equality ----
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_alu_result_buffer
// Directed scenarios followed by a randomized phase, all checked against a
// queue-based reference model of the buffer contents.
// ---------------------------------------------------------------------------
module tb_alu_result_buffer;
    localparam int DW = 32;
    localparam int D  = 2;

    typedef struct {
        logic [DW-1:0] zl;
        logic [DW-1:0] zh;
        logic          w;
        logic          z;
        logic          n;
    } entry_t;

    logic clock = 1'b0;
    logic clear;
    logic flush;

    alu_result_buffer_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();

    alu_result_buffer #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clock (clock),
        .clear (clear),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    entry_t q[$];
    int     n_vec = 0;
    int     n_err = 0;

    // Reference entry computed from the result value as a whole number.
    function automatic entry_t mk(input logic [DW-1:0] zl,
                                  input logic [DW-1:0] zh,
                                  input logic          w);
        entry_t e;
        logic [2*DW-1:0] full;
        full = {zh, zl};
        e.zl = zl;
        e.zh = w ? zh : '0;
        e.w  = w;
        if (w) begin
            e.z = (full == 0);
            e.n = ($signed(full) < 0);
        end else begin
            e.z = (zl == 0);
            e.n = ($signed(zl) < 0);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("count",     64'(bus.count),     64'(q.size()));
        chk("in_ready",  64'(bus.in_ready),  64'(q.size() != D));
        if (q.size() != 0) begin
            chk("out_zlow",  64'(bus.out_zlow),  64'(q[0].zl));
            chk("out_zhigh", 64'(bus.out_zhigh), 64'(q[0].zh));
            chk("out_wide",  64'(bus.out_wide),  64'(q[0].w));
            chk("out_zero",  64'(bus.out_zero),  64'(q[0].z));
            chk("out_neg",   64'(bus.out_neg),   64'(q[0].n));
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] zl, input logic [DW-1:0] zh,
                         input logic w, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_zlow   = zl;
        bus.in_zhigh  = zh;
        bus.in_wide   = w;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    // Called at a falling edge with inputs applied; advances one clock and
    // updates the model from what the rules say happens at that edge.
    task automatic step();
        bit     push;
        bit     pop;
        entry_t e;
        chk("in_ready_pre", 64'(bus.in_ready), 64'(q.size() != D));
        push = bus.in_valid && (q.size() < D);
        pop  = bus.out_ready && (q.size() > 0);
        e    = mk(bus.in_zlow, bus.in_zhigh, bus.in_wide);
        @(posedge clock);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(e);
        end
        check_state();
        @(negedge clock);
    endtask

    initial begin
        clear = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count",     64'(bus.count),     64'd0);
        chk("rst_out_zlow",  64'(bus.out_zlow),  64'd0);
        chk("rst_out_zhigh", 64'(bus.out_zhigh), 64'd0);
        chk("rst_out_wide",  64'(bus.out_wide),  64'd0);
        chk("rst_out_zero",  64'(bus.out_zero),  64'd0);
        chk("rst_out_neg",   64'(bus.out_neg),   64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clock);
        clear = 1'b0;

        // single narrow push
        drive(1'b1, 32'h8000_0001, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        step();
        chk("narrow_zlow",  64'(bus.out_zlow),  64'h8000_0001);
        chk("narrow_zhigh", 64'(bus.out_zhigh), 64'd0);
        chk("narrow_neg",   64'(bus.out_neg),   64'd1);
        chk("narrow_zero",  64'(bus.out_zero),  64'd0);
        chk("narrow_count", 64'(bus.count),     64'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();

        // wide zero flag
        drive(1'b1, 32'h0, 32'h1, 1'b1, 1'b0, 1'b0);
        step();
        chk("wide1_zero", 64'(bus.out_zero), 64'd0);
        chk("wide1_neg",  64'(bus.out_neg),  64'd0);
        drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step();
        chk("wide2_zero", 64'(bus.out_zero), 64'd1);
        step();

        // fill and back-pressure
        drive(1'b1, 32'h11, '0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h22, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_count",    64'(bus.count),    64'd2);
        drive(1'b1, 32'h33, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk("full_head", 64'(bus.out_zlow), 64'h11);
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step();
        chk("pop1_head", 64'(bus.out_zlow), 64'h22);
        step();
        chk("pop2_empty", 64'(bus.out_valid), 64'd0);

        // streaming
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), '0, 1'b0, 1'b1, 1'b0);
            step();
            chk("stream_zlow",  64'(bus.out_zlow), 64'(i));
            chk("stream_count", 64'(bus.count),    64'd1);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        step();

        // flush with concurrent traffic
        drive(1'b1, 32'h1, '0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h2, '0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hAA, '0, 1'b0, 1'b1, 1'b1);
        step();
        chk("flush_count", 64'(bus.count),     64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        step();

        // asynchronous clear between edges
        drive(1'b1, 32'h77, '0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #2 clear = 1'b1;
        #1;
        chk("aclr_valid", 64'(bus.out_valid), 64'd0);
        chk("aclr_count", 64'(bus.count),     64'd0);
        q.delete();
        #1 clear = 1'b0;
        @(negedge clock);
        drive(1'b1, 32'h5, '0, 1'b0, 1'b0, 1'b0);
        step();
        chk("aclr_push", 64'(bus.out_zlow), 64'h5);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] zl;
            logic [DW-1:0] zh;
            zl = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            zh = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            drive(1'($urandom_range(0, 1)), zl, zh, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
